// File: rtl/spi_slave_sync_if.sv
// Bus bundle for spi_slave_sync: the master's serial lines plus the host-side
// word/strobe signals.
interface spi_slave_sync_if #(
    parameter int M = 8
);
    logic         LOAD;
    logic         SCLK;
    logic         MOSI;
    logic         MISO;
    logic [M-1:0] tx_dat;
    logic [M-1:0] rx_dat;
    logic         rx_vld;
    logic         err;
    logic         tx_ld;
    logic         busy;

    modport slave (
        input  LOAD, SCLK, MOSI, tx_dat,
        output MISO, rx_dat, rx_vld, err, tx_ld, busy
    );

    modport master (
        output LOAD, SCLK, MOSI, tx_dat,
        input  MISO, rx_dat, rx_vld, err, tx_ld, busy
    );
endinterface

// File: rtl/spi_slave_sync.sv
// SPI responder clocked by clk: oversamples LOAD/SCLK/MOSI, shifts tx word out
// MSB-first, assembles the received word and reports frame results as pulses.
//
// state  | meaning
// SYNC   | after reset; wait for LOAD high before accepting any frame
// IDLE   | LOAD high, waiting for LOAD fall
// ACTIVE | frame in progress, shifting on SCLK edges
module spi_slave_sync #(
    parameter int M = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_slave_sync_if.slave  bus
);
    localparam int CW = $clog2(M + 2);

    typedef enum logic [1:0] {SYNC, IDLE, ACTIVE} state_t;

    state_t state_q, state_d;

    logic load_s1_q, load_s2_q, load_h_q;
    logic sck_s1_q, sck_s2_q, sck_h_q;
    logic mosi_s1_q, mosi_s2_q, mosi_s3_q;
    logic ld_fall_q, ld_rise_q, sck_rise_q, sck_fall_q;
    logic armed_q;

    logic [M-1:0]  sr_tx_q, sr_tx_d;
    logic [M-1:0]  sr_rx_q, sr_rx_d;
    logic [M-1:0]  rx_dat_q, rx_dat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rx_vld_q, rx_vld_d;
    logic          err_q, err_d;
    logic          tx_ld_q, tx_ld_d;

    // Edge flags are registered; MOSI gets a third stage to stay aligned with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_s1_q  <= 1'b1;
            load_s2_q  <= 1'b1;
            load_h_q   <= 1'b1;
            sck_s1_q   <= 1'b0;
            sck_s2_q   <= 1'b0;
            sck_h_q    <= 1'b0;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            mosi_s3_q  <= 1'b0;
            ld_fall_q  <= 1'b0;
            ld_rise_q  <= 1'b0;
            sck_rise_q <= 1'b0;
            sck_fall_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            load_s1_q  <= bus.LOAD;
            load_s2_q  <= load_s1_q;
            load_h_q   <= load_s2_q;
            sck_s1_q   <= bus.SCLK;
            sck_s2_q   <= sck_s1_q;
            sck_h_q    <= sck_s2_q;
            mosi_s1_q  <= bus.MOSI;
            mosi_s2_q  <= mosi_s1_q;
            mosi_s3_q  <= mosi_s2_q;
            ld_fall_q  <= load_h_q & ~load_s2_q;
            ld_rise_q  <= ~load_h_q & load_s2_q;
            sck_rise_q <= ~sck_h_q & sck_s2_q;
            sck_fall_q <= sck_h_q & ~sck_s2_q;
            armed_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SYNC;
        else        state_q <= state_d;
    end

    // Leaving SYNC needs one real pin sample in the chain, since it resets to 1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (armed_q && load_s1_q && load_s2_q && load_h_q) state_d = IDLE;
            IDLE:    if (ld_fall_q) state_d = ACTIVE;
            ACTIVE:  if (ld_rise_q) state_d = IDLE;
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        sr_tx_d  = sr_tx_q;
        sr_rx_d  = sr_rx_q;
        cnt_d    = cnt_q;
        rx_dat_d = rx_dat_q;
        rx_vld_d = 1'b0;
        err_d    = 1'b0;
        tx_ld_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_fall_q) begin
                    sr_tx_d = bus.tx_dat;
                    sr_rx_d = '0;
                    cnt_d   = '0;
                    tx_ld_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (ld_rise_q) begin
                    if (cnt_q == CW'(M)) begin
                        rx_dat_d = sr_rx_q;
                        rx_vld_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    if (sck_rise_q) begin
                        sr_rx_d = {sr_rx_q[M-2:0], mosi_s3_q};
                        if (cnt_q != CW'(M + 1)) cnt_d = cnt_q + CW'(1);
                    end
                    if (sck_fall_q) sr_tx_d = sr_tx_q << 1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_tx_q  <= '0;
            sr_rx_q  <= '0;
            cnt_q    <= '0;
            rx_dat_q <= '0;
            rx_vld_q <= 1'b0;
            err_q    <= 1'b0;
            tx_ld_q  <= 1'b0;
        end else begin
            sr_tx_q  <= sr_tx_d;
            sr_rx_q  <= sr_rx_d;
            cnt_q    <= cnt_d;
            rx_dat_q <= rx_dat_d;
            rx_vld_q <= rx_vld_d;
            err_q    <= err_d;
            tx_ld_q  <= tx_ld_d;
        end
    end

    always_comb begin
        bus.MISO   = (state_q == ACTIVE) ? sr_tx_q[M-1] : 1'b0;
        bus.busy   = (state_q == ACTIVE);
        bus.rx_dat = rx_dat_q;
        bus.rx_vld = rx_vld_q;
        bus.err    = err_q;
        bus.tx_ld  = tx_ld_q;
    end
endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: a behavioural SPI master drives frames from a
// vector table, hand-written corner sequences and random frames.
module tb_spi_slave_sync;
    localparam int M = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    spi_slave_sync_if #(.M(M)) bus ();

    spi_slave_sync #(.M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // pulse monitor, sampled 1 ns after each rising edge
    int n_txld, n_vld, n_err;
    int txld_cyc, vld_cyc, err_cyc;
    logic miso_txld;

    always @(posedge clk) begin
        #1;
        if (bus.tx_ld) begin
            n_txld++;
            txld_cyc  = cyc;
            miso_txld = bus.MISO;
        end
        if (bus.rx_vld) begin
            n_vld++;
            vld_cyc = cyc;
        end
        if (bus.err) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [M-1:0] mtx;
        logic [M-1:0] txd;
        int           nbits;
        int           nce;
        int           gap;
        logic         exp_vld;
        logic         exp_err;
        logic [M-1:0] exp_rx;
        logic [M-1:0] exp_mrx;
    } vec_t;

    vec_t vecs[6];

    logic [M-1:0] mtx_sh, mrx, exp_rx;
    int fall_cyc, rise_cyc;
    logic chg_tx = 1'b0;
    logic [M-1:0] tx_new;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        n_txld = 0; n_vld = 0; n_err = 0;
        txld_cyc = -1; vld_cyc = -1; err_cyc = -1;
        miso_txld = 1'b0;
    endtask

    task automatic ld_low(input logic [M-1:0] mtx, input int nce);
        clr_mon();
        mtx_sh   = mtx;
        mrx      = '0;
        bus.LOAD = 1'b0;
        bus.MOSI = mtx_sh[M-1];
        fall_cyc = cyc;
        for (int i = 1; i <= nce; i++) begin
            tick();
            if (chg_tx && i == 5) bus.tx_dat = tx_new;
        end
    endtask

    task automatic send_bit(input int nce);
        mrx      = {mrx[M-2:0], bus.MISO};
        bus.SCLK = 1'b1;
        repeat (nce) tick();
        bus.SCLK = 1'b0;
        mtx_sh   = mtx_sh << 1;
        bus.MOSI = mtx_sh[M-1];
        repeat (nce) tick();
    endtask

    task automatic ld_high();
        bus.LOAD = 1'b1;
        rise_cyc = cyc;
    endtask

    task automatic gap(input int g);
        repeat (g) tick();
        #1;
        chk("idle MISO", bus.MISO, 0);
        chk("idle busy", bus.busy, 0);
    endtask

    task automatic run_frame(input logic [M-1:0] mtx, input logic [M-1:0] txd,
                             input int nbits, input int nce, input int g,
                             input logic e_vld, input logic e_err,
                             input logic [M-1:0] e_rx, input logic [M-1:0] e_mrx);
        bus.tx_dat = txd;
        ld_low(mtx, nce);
        for (int b = 0; b < nbits; b++) send_bit(nce);
        ld_high();
        gap(g);
        chk("tx_ld count", n_txld, 1);
        chk("tx_ld latency", txld_cyc - fall_cyc, 4);
        chk("MISO first bit", miso_txld, txd[M-1]);
        chk("rx_vld count", n_vld, e_vld);
        chk("err count", n_err, e_err);
        if (e_vld) begin
            chk("rx_vld latency", vld_cyc - rise_cyc, 4);
            chk("master rx", mrx, e_mrx);
        end
        if (e_err) chk("err latency", err_cyc - rise_cyc, 4);
        chk("rx_dat", bus.rx_dat, e_rx);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 8,  8, 6, 1'b1, 1'b0, 8'hA5, 8'h3C};
        vecs[1] = '{8'h12, 8'h66, 5,  5, 4, 1'b0, 1'b1, 8'hA5, 8'h00};
        vecs[2] = '{8'hE7, 8'h99, 10, 6, 4, 1'b0, 1'b1, 8'hA5, 8'h00};
        vecs[3] = '{8'h01, 8'h81, 8,  5, 4, 1'b1, 1'b0, 8'h01, 8'h81};
        vecs[4] = '{8'h80, 8'h7E, 8,  5, 4, 1'b1, 1'b0, 8'h80, 8'h7E};
        vecs[5] = '{8'hFF, 8'h00, 8,  5, 4, 1'b1, 1'b0, 8'hFF, 8'h00};

        bus.LOAD = 1'b1;
        bus.SCLK = 1'b0;
        bus.MOSI = 1'b0;
        bus.tx_dat = '0;
        clr_mon();
        repeat (3) tick();
        chk("reset MISO", bus.MISO, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset rx_dat", bus.rx_dat, 0);
        chk("reset rx_vld", bus.rx_vld, 0);
        chk("reset err", bus.err, 0);
        chk("reset tx_ld", bus.tx_ld, 0);
        rst_n = 1'b1;
        repeat (6) tick();
        exp_rx = '0;

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].mtx, vecs[i].txd, vecs[i].nbits, vecs[i].nce, vecs[i].gap,
                      vecs[i].exp_vld, vecs[i].exp_err, vecs[i].exp_rx, vecs[i].exp_mrx);
        end
        exp_rx = 8'hFF;

        // reset in the middle of a frame, released while LOAD is still low
        bus.tx_dat = 8'h77;
        ld_low(8'hC6, 8);
        repeat (3) send_bit(8);
        rst_n = 1'b0;
        #1;
        chk("mid-reset MISO", bus.MISO, 0);
        chk("mid-reset busy", bus.busy, 0);
        chk("mid-reset rx_dat", bus.rx_dat, 0);
        chk("mid-reset pulses", {bus.rx_vld, bus.err, bus.tx_ld}, 0);
        exp_rx = '0;
        tick();
        tick();
        rst_n = 1'b1;
        clr_mon();
        repeat (5) send_bit(8);
        ld_high();
        gap(6);
        chk("post-reset tx_ld", n_txld, 0);
        chk("post-reset rx_vld", n_vld, 0);
        chk("post-reset err", n_err, 0);
        chk("post-reset rx_dat", bus.rx_dat, 0);
        run_frame(8'h5A, 8'h96, 8, 6, 4, 1'b1, 1'b0, 8'h5A, 8'h96);

        // host changes tx_dat one cycle after tx_ld
        tx_new = 8'hC3;
        chg_tx = 1'b1;
        run_frame(8'h3D, 8'h3C, 8, 8, 4, 1'b1, 1'b0, 8'h3D, 8'h3C);
        chg_tx = 1'b0;
        chk("tx_dat held by host", bus.tx_dat, 8'hC3);
        run_frame(8'h4E, 8'hC3, 8, 8, 4, 1'b1, 1'b0, 8'h4E, 8'hC3);
        exp_rx = 8'h4E;

        // random frames against the word-level model
        for (int k = 0; k < 25; k++) begin
            logic [M-1:0] r_mtx, r_txd;
            int r_nb, r_nce, r_gap;
            logic good;
            r_mtx = M'($urandom);
            r_txd = M'($urandom);
            r_nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, M + 3)) : M;
            r_nce = $urandom_range(5, 9);
            r_gap = $urandom_range(4, 8);
            good  = (r_nb == M);
            if (good) exp_rx = r_mtx;
            run_frame(r_mtx, r_txd, r_nb, r_nce, r_gap, good, !good, exp_rx, r_txd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Synchronous SPI slave (responder) for the team's SPI master, running entirely in the system clock domain. It oversamples the master's LOAD/SCLK/MOSI lines through synchronizers and edge detectors. It shifts a host-supplied word out on MISO MSB-first and assembles the received word. Received data, frame completion and frame errors are reported as single-cycle pulses to on-chip logic. Protocol matches the master: LOAD idles high and is low for the frame, SCLK idles low, data changes on SCLK fall and is sampled on SCLK rise.

## Interface
- `M`, 8, word width in bits (≥ 2)
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `LOAD`  in  1  frame strobe from master, active low, asynchronous to `clk`
- `SCLK`  in  1  serial clock from master, idle 0, asynchronous to `clk`
- `MOSI`  in  1  serial data from master, asynchronous to `clk`
- `tx_dat`  in  M  word to transmit; captured at frame start
- `MISO`  out  1  serial data to master
- `rx_dat`  out  M  last correctly received word
- `rx_vld`  out  1  1-cycle pulse: `rx_dat` updated
- `err`  out  1  1-cycle pulse: frame ended with bit count ≠ M
- `tx_ld`  out  1  1-cycle pulse: `tx_dat` captured; host may change it
- `busy`  out  1  high while a frame is active

## Operation
- Synchronizers: 2-FF chains on LOAD, SCLK and MOSI, plus one history register each for LOAD and SCLK. Reset values are LOAD chain = 1 and SCLK chain = 0. MOSI uses the same depth as SCLK so that they stay aligned.
- Edge flags are derived from synced vs. history values: `ld_fall`, `ld_rise`, `sck_rise`, `sck_fall`.
- FSM states:
  - SYNC (reset state): waits until synced LOAD = 1, then goes to IDLE. No frame may start from SYNC. This ignores a frame already in progress at reset release.
  - IDLE: on `ld_fall`, capture `tx_dat` into `sr_tx`, clear `sr_rx` and `cnt`, pulse `tx_ld`, go to ACTIVE.
  - ACTIVE: on `sck_rise`, `sr_rx <= {sr_rx[M-2:0], MOSI_sync}` and `cnt` increments, saturating at M+1. On `sck_fall`, `sr_tx <= sr_tx << 1`. On `ld_rise`: if `cnt == M`, `rx_dat <= sr_rx` and pulse `rx_vld`; otherwise pulse `err` and leave `rx_dat` unchanged. In both cases go to IDLE.
- `ld_rise` has priority over SCLK edges in the same cycle; those SCLK edges are discarded.
- `cnt` is ceil(log2(M+2)) bits. Both overrun (> M rises) and underrun (< M rises) raise `err`.
- MISO = `sr_tx[M-1]` in ACTIVE and 0 otherwise.
- `busy` = (state == ACTIVE).
- Reset (asynchronous, any time, including mid-frame):
  - FSM goes to SYNC.
  - `sr_tx`, `sr_rx`, `cnt` and `rx_dat` go to 0.
  - `rx_vld`, `err`, `tx_ld`, `busy` and `MISO` go to 0.

## Timing
- Pin-to-edge-flag latency is 3 clk: 2 synchronizer stages plus 1 history stage. Actions on a flag are registered, so they become visible 4 clk after the pin change.
- At frame start, MISO carries `tx_dat[M-1]` 4 clk after LOAD falls. `tx_ld` is asserted in that same cycle.
- After each SCLK fall, the next MISO bit is valid 4 clk later.
- `rx_vld`/`err` assert 4 clk after LOAD rises, for exactly 1 cycle.
- Master constraints:
  - SCLK half-period ≥ 5 clk (master Nce ≥ 5).
  - First SCLK rise ≥ 5 clk after LOAD falls.
  - LOAD high time between frames ≥ 4 clk.
  - MOSI stable ≥ 1 clk before and after each SCLK rise.
  - Violating any of these is undefined behaviour; the block must not hang and must recover at the next LOAD high.
- Throughput is one word per frame. `tx_dat` is sampled only in the `tx_ld` cycle.

## Test plan
- Reset with LOAD=1, then a frame with master `MTX_DAT`=0xA5, `tx_dat`=0x3C, Nce=8, M=8:
  - one `tx_ld` pulse;
  - master receives 0x3C;
  - `rx_dat`=0xA5 with one `rx_vld` pulse 4 clk after LOAD rises;
  - `err` stays 0.
- Back-to-back frames 0x01, 0x80, 0xFF with LOAD high gap = 4 clk:
  - three `rx_vld` pulses with the matching `rx_dat` values;
  - MISO returns 0 in every IDLE gap.
- Short frame (LOAD raised after 5 SCLK rises):
  - `err` pulses once;
  - `rx_vld` stays 0;
  - `rx_dat` keeps its previous value (0xA5).
- Long frame (10 SCLK rises, M=8): `err` pulses once and `rx_dat` is unchanged.
- Assert `rst_n`=0 mid-frame (after 3 bits) and release while LOAD is still low:
  - outputs go to 0 immediately;
  - no `tx_ld`/`rx_vld`/`err` for the remainder of that frame;
  - the next full frame (0x5A) is received correctly.
- Change `tx_dat` from 0x3C to 0xC3 one cycle after `tx_ld`: the master still receives 0x3C for the current frame and 0xC3 in the next frame.
